// File: rtl/rom_master_pkg.sv
// rtl/rom_master_pkg.sv - shared types and constants for the boot ROM read master
package rom_master_pkg;

  typedef enum logic [1:0] {
    BOOT_LO = 2'd0,
    BOOT_HI = 2'd1,
    IDLE    = 2'd2,
    WAIT    = 2'd3
  } state_t;

  localparam logic [1:0]  ROM_WIN_MSB      = 2'b11;
  localparam logic [11:0] VEC_LO           = 12'hFFC;
  localparam logic [11:0] VEC_HI           = 12'hFFD;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'hFF;

  // The ROM image is mirrored across 0xC000-0xFFFF; only the top two address bits decide.
  function automatic logic in_rom_window(input logic [1:0] addr_msb);
    return addr_msb == ROM_WIN_MSB;
  endfunction

endpackage

// File: rtl/rom_read_master.sv
// rtl/rom_read_master.sv - 6502 read initiator for the registered-read boot ROM
module rom_read_master
  import rom_master_pkg::*;
#(
  parameter int         TIMEOUT  = 15,
  parameter logic [7:0] OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic        cpu_rdy,
  output logic        cpu_ack,
  output logic [7:0]  cpu_data,
  output logic        cpu_err,
  input  logic        cache_flush,
  output logic [15:0] reset_vector,
  output logic        boot_done,
  output logic [11:0] rom_address,
  output logic        rom_oe,
  input  logic        rom_valid,
  input  logic [7:0]  rom_q
);

  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  state_t        state;
  logic          boot_issued;
  logic [CW-1:0] wait_cnt;
  logic          cache_valid;
  logic [11:0]   cache_tag;
  logic [7:0]    cache_data;
  logic [7:0]    vec_lo;
  logic [7:0]    vec_hi;
  logic          resp;
  logic          expired;
  logic          cache_hit;
  logic [1:0]    unused_addr_bits;

  // Mirrored window: bits 13:12 never select anything.
  assign unused_addr_bits = cpu_addr[13:12];

  // A response is only legal one cycle after the strobe, so a valid coinciding
  // with our own strobe cycle is stale and must not complete the read.
  assign resp    = rom_valid && !rom_oe;
  assign expired = !rom_oe && !rom_valid && (wait_cnt == CW'(TIMEOUT));

  // A flush in the acceptance cycle beats the hit.
  assign cache_hit = cache_valid && !cache_flush && (cache_tag == cpu_addr[11:0]);

  assign reset_vector = {vec_hi, vec_lo};

  // Boot vector fetch, request arbitration, ROM wait/timeout and cache upkeep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT_LO;
      boot_issued <= 1'b0;
      wait_cnt    <= '0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      vec_lo      <= '0;
      vec_hi      <= '0;
      cpu_rdy     <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_data    <= OPEN_BUS;
      boot_done   <= 1'b0;
      rom_address <= '0;
      rom_oe      <= 1'b0;
    end else begin
      rom_oe  <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      // A fill later in this block overrides this clear.
      if (cache_flush) cache_valid <= 1'b0;

      case (state)
        BOOT_LO, BOOT_HI: begin
          if (!boot_issued) begin
            boot_issued <= 1'b1;
            rom_address <= VEC_LO;
            rom_oe      <= 1'b1;
            wait_cnt    <= '0;
          end else if (resp) begin
            if (state == BOOT_LO) begin
              vec_lo      <= rom_q;
              rom_address <= VEC_HI;
              rom_oe      <= 1'b1;
              wait_cnt    <= '0;
              state       <= BOOT_HI;
            end else begin
              vec_hi      <= rom_q;
              boot_done   <= 1'b1;
              boot_issued <= 1'b0;
              cpu_rdy     <= 1'b1;
              state       <= IDLE;
            end
          end else if (!rom_oe) begin
            // No answer in time: re-strobe the same vector address.
            if (wait_cnt == CW'(TIMEOUT)) begin
              rom_oe   <= 1'b1;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end

        IDLE: begin
          if (cpu_req) begin
            if (!in_rom_window(cpu_addr[15:14])) begin
              cpu_ack  <= 1'b1;
              cpu_data <= OPEN_BUS;
            end else if (cache_hit) begin
              cpu_ack  <= 1'b1;
              cpu_data <= cache_data;
            end else begin
              rom_address <= cpu_addr[11:0];
              rom_oe      <= 1'b1;
              wait_cnt    <= '0;
              cpu_rdy     <= 1'b0;
              state       <= WAIT;
            end
          end
        end

        WAIT: begin
          if (resp) begin
            cpu_data    <= rom_q;
            cache_data  <= rom_q;
            cache_tag   <= rom_address;
            cache_valid <= 1'b1;
            cpu_ack     <= 1'b1;
            cpu_rdy     <= 1'b1;
            state       <= IDLE;
          end else if (expired) begin
            cpu_data    <= OPEN_BUS;
            cpu_ack     <= 1'b1;
            cpu_err     <= 1'b1;
            cache_valid <= 1'b0;
            cpu_rdy     <= 1'b1;
            state       <= IDLE;
          end else if (!rom_oe) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= BOOT_LO;
      endcase
    end
  end

endmodule
